// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between fetch and memctrl.
// Hits return in one cycle; a miss requests one word, fills the line and forwards it.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  logic                r_cancel;
  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag_arr  [LINES];
  logic [31:0]         r_data_arr [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_unused;

  assign w_idx      = fetch_addr[INDEX_BITS+1:2];
  assign w_tag      = fetch_addr[31:INDEX_BITS+2];
  // The outstanding miss address doubles as the latched fill index/tag.
  assign w_fill_idx = mem_addr[INDEX_BITS+1:2];
  assign w_fill_tag = mem_addr[31:INDEX_BITS+2];
  assign w_hit      = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign w_fill     = rdy_in && (r_state == S_WAIT) && mem_done;
  assign w_unused   = ^fetch_addr[1:0];

  // Tag and data arrays carry no reset; only the valid bits do.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag_arr[w_fill_idx]  <= w_fill_tag;
      r_data_arr[w_fill_idx] <= mem_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cancel    <= 1'b0;
      r_valid     <= '0;
      fetch_ready <= 1'b0;
      fetch_inst  <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy_in) begin
      fetch_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_valid && !flush) begin
            if (w_hit) begin
              fetch_ready <= 1'b1;
              fetch_inst  <= r_data_arr[w_idx];
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {fetch_addr[31:2], 2'b00};
              r_cancel <= 1'b0;
              r_state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_req            <= 1'b0;
            r_valid[w_fill_idx] <= 1'b1;
            r_cancel           <= 1'b0;
            r_state            <= S_IDLE;
            // A redirect seen at any point of the miss still fills, but is not answered.
            if (!r_cancel && !flush) begin
              fetch_ready <= 1'b1;
              fetch_inst  <= mem_data;
            end
          end else if (flush) begin
            r_cancel <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed vector table, hand-written corner sequences and
// randomized fetches checked against an address-level cache/memory model.
module tb_icache;
  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        flush;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  int n_cmp = 0;
  int n_err = 0;

  icache #(.INDEX_BITS(4)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_ready (fetch_ready),
    .fetch_inst  (fetch_inst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_data    (mem_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Reference model: 16 lines addressed by word number mod 16, tag = byte address / 64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_data  [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] mdata;
    bit          hit;
    logic [31:0] inst;
    int          lat;
  } vec_t;
  vec_t vecs [9];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
    int ix;
    ix = int'((a / 4) % 16);
    m_valid[ix] = 1'b1;
    m_tag[ix]   = a / 64;
    m_data[ix]  = d;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n, input string nm);
    fetch_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      chk({nm, " idle ready"}, 32'(fetch_ready), 32'd0);
      chk({nm, " idle req"}, 32'(mem_req), 32'd0);
    end
  endtask

  // One fetch transaction, with the bench acting as memctrl on a miss.
  task automatic do_fetch(input logic [31:0] addr, input int lat, input logic [31:0] mdata,
                          input bit exp_hit, input logic [31:0] exp_inst, input string nm);
    logic [31:0] al;
    al = addr & 32'hFFFF_FFFC;
    fetch_valid = 1'b1;
    fetch_addr  = addr;
    step();
    if (exp_hit) begin
      chk({nm, " hit ready"}, 32'(fetch_ready), 32'd1);
      chk({nm, " hit inst"}, fetch_inst, exp_inst);
      chk({nm, " hit no req"}, 32'(mem_req), 32'd0);
      fetch_valid = 1'b0;
    end else begin
      chk({nm, " miss req"}, 32'(mem_req), 32'd1);
      chk({nm, " miss addr"}, mem_addr, al);
      chk({nm, " miss no ready"}, 32'(fetch_ready), 32'd0);
      for (int k = 0; k < lat; k++) begin
        step();
        chk({nm, " wait req"}, 32'(mem_req), 32'd1);
        chk({nm, " wait ready"}, 32'(fetch_ready), 32'd0);
      end
      mem_done = 1'b1;
      mem_data = mdata;
      step();
      mem_done = 1'b0;
      chk({nm, " fill ready"}, 32'(fetch_ready), 32'd1);
      chk({nm, " fill inst"}, fetch_inst, exp_inst);
      chk({nm, " fill req drop"}, 32'(mem_req), 32'd0);
      fetch_valid = 1'b0;
      model_fill(al, mdata);
    end
    $display("fetch %s addr=%h hit=%0b inst=%h", nm, addr, exp_hit, fetch_inst);
  endtask

  task automatic async_reset_pulse();
    #2 rst_in = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    model_clear();
  endtask

  // memctrl only answers an outstanding request.
  always @(posedge clk_in) begin
    if (mem_done && rdy_in && !rst_in) begin
      n_cmp++;
      if (!mem_req) begin
        n_err++;
        $display("FAIL protocol: mem_done with mem_req=%0b", mem_req);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] al;
    int ix;
    bit h;

    rst_in = 1'b0; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_addr = '0;
    flush = 1'b0; mem_done = 1'b0; mem_data = '0;
    model_clear();

    vecs[0] = '{32'h0000_0000, 32'h0000_0093, 1'b0, 32'h0000_0093, 2};
    vecs[1] = '{32'h0000_0000, 32'h0,         1'b1, 32'h0000_0093, 0};
    vecs[2] = '{32'h0000_0002, 32'h0,         1'b1, 32'h0000_0093, 0};
    vecs[3] = '{32'h0000_0004, 32'h1111_1111, 1'b0, 32'h1111_1111, 1};
    vecs[4] = '{32'h0000_0044, 32'h2222_2222, 1'b0, 32'h2222_2222, 3};
    vecs[5] = '{32'h0000_0004, 32'h1111_1111, 1'b0, 32'h1111_1111, 0};
    vecs[6] = '{32'h0000_0044, 32'h2222_2222, 1'b0, 32'h2222_2222, 1};
    vecs[7] = '{32'h0000_0047, 32'h0,         1'b1, 32'h2222_2222, 0};
    vecs[8] = '{32'h0000_0003, 32'h0,         1'b1, 32'h0000_0093, 0};

    // Asynchronous reset before any clock edge
    #2 rst_in = 1'b1;
    #1;
    chk("reset ready", 32'(fetch_ready), 32'd0);
    chk("reset inst", fetch_inst, 32'd0);
    chk("reset req", 32'(mem_req), 32'd0);
    chk("reset addr", mem_addr, 32'd0);
    release_reset();

    // Directed table: first miss, hits, aliasing evictions
    for (int i = 0; i < 9; i++)
      do_fetch(vecs[i].addr, vecs[i].lat, vecs[i].mdata, vecs[i].hit, vecs[i].inst,
               $sformatf("vec%0d", i));
    idle(1, "after table");

    // Flush in IDLE: neither a hit nor a miss is acted on
    fetch_valid = 1'b1; fetch_addr = 32'h44; flush = 1'b1;
    step();
    chk("idle flush hit ready", 32'(fetch_ready), 32'd0);
    fetch_addr = 32'h300;
    step();
    chk("idle flush miss req", 32'(mem_req), 32'd0);
    chk("idle flush miss ready", 32'(fetch_ready), 32'd0);
    flush = 1'b0; fetch_valid = 1'b0;
    $display("seq idle-flush done");

    // Flush two cycles before mem_done: line filled, no response
    fetch_valid = 1'b1; fetch_addr = 32'h100;
    step();
    chk("t4 req", 32'(mem_req), 32'd1);
    chk("t4 addr", mem_addr, 32'h100);
    flush = 1'b1; fetch_valid = 1'b0;
    step();
    flush = 1'b0;
    chk("t4 req hold1", 32'(mem_req), 32'd1);
    chk("t4 ready1", 32'(fetch_ready), 32'd0);
    step();
    chk("t4 req hold2", 32'(mem_req), 32'd1);
    chk("t4 addr hold", mem_addr, 32'h100);
    mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_done = 1'b0;
    chk("t4 cancelled ready", 32'(fetch_ready), 32'd0);
    chk("t4 req drop", 32'(mem_req), 32'd0);
    model_fill(32'h100, 32'hDEAD_BEEF);
    $display("seq flush-before-done done");
    idle(1, "t4");
    do_fetch(32'h100, 0, 32'h0, 1'b1, 32'hDEAD_BEEF, "t4 refetch");

    // Flush in the same cycle as mem_done
    fetch_valid = 1'b1; fetch_addr = 32'h200;
    step();
    chk("t4b req", 32'(mem_req), 32'd1);
    step();
    mem_done = 1'b1; mem_data = 32'h0BAD_F00D; flush = 1'b1; fetch_valid = 1'b0;
    step();
    mem_done = 1'b0; flush = 1'b0;
    chk("t4b ready", 32'(fetch_ready), 32'd0);
    chk("t4b req drop", 32'(mem_req), 32'd0);
    model_fill(32'h200, 32'h0BAD_F00D);
    $display("seq flush-with-done done");
    do_fetch(32'h200, 0, 32'h0, 1'b1, 32'h0BAD_F00D, "t4b refetch");

    // rdy_in low during WAIT freezes everything, including flush
    fetch_valid = 1'b1; fetch_addr = 32'h8;
    step();
    chk("t5 req", 32'(mem_req), 32'd1);
    rdy_in = 1'b0; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5 frozen req", 32'(mem_req), 32'd1);
      chk("t5 frozen addr", mem_addr, 32'h8);
      chk("t5 frozen ready", 32'(fetch_ready), 32'd0);
    end
    rdy_in = 1'b1; flush = 1'b0; mem_done = 1'b1; mem_data = 32'hCAFE_F00D;
    step();
    mem_done = 1'b0; fetch_valid = 1'b0;
    chk("t5 ready", 32'(fetch_ready), 32'd1);
    chk("t5 inst", fetch_inst, 32'hCAFE_F00D);
    chk("t5 req drop", 32'(mem_req), 32'd0);
    model_fill(32'h8, 32'hCAFE_F00D);
    idle(1, "t5");
    rdy_in = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h8;
    step();
    chk("t5 frozen hit", 32'(fetch_ready), 32'd0);
    step();
    chk("t5 frozen hit2", 32'(fetch_ready), 32'd0);
    rdy_in = 1'b1;
    step();
    fetch_valid = 1'b0;
    chk("t5 thaw hit ready", 32'(fetch_ready), 32'd1);
    chk("t5 thaw hit inst", fetch_inst, 32'hCAFE_F00D);
    $display("seq rdy-freeze done");

    // Mid-cycle asynchronous reset: during a hit pulse, then during WAIT
    do_fetch(32'h0, 1, 32'h0000_0093, 1'b0, 32'h0000_0093, "t6 refill");
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_valid = 1'b0;
    chk("t6 hit ready", 32'(fetch_ready), 32'd1);
    async_reset_pulse();
    chk("t6 async ready", 32'(fetch_ready), 32'd0);
    chk("t6 async inst", fetch_inst, 32'd0);
    release_reset();
    fetch_valid = 1'b1; fetch_addr = 32'hC;
    step();
    fetch_valid = 1'b0;
    chk("t6 wait req", 32'(mem_req), 32'd1);
    async_reset_pulse();
    chk("t6 async req", 32'(mem_req), 32'd0);
    chk("t6 async addr", mem_addr, 32'd0);
    release_reset();
    $display("seq async-reset done");
    idle(2, "t6");
    do_fetch(32'h0, 2, 32'h0000_0093, 1'b0, 32'h0000_0093, "t6 cold");

    // Randomized fetches against the model
    for (int i = 0; i < 250; i++) begin
      a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      al = a & 32'hFFFF_FFFC;
      ix = int'((al / 4) % 16);
      h  = m_valid[ix] && (m_tag[ix] == al / 64);
      do_fetch(a, int'($urandom_range(0, 4)), mem_fn(al), h,
               h ? m_data[ix] : mem_fn(al), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
